sequence_checker: RTL and testbench

SEQUENCE_CHECKER -- requirements
Module: sequence_checker

---
 rtl/sequence_checker.sv | 232 +++++++++++++++++++++++
 tb/tb_sequence_checker.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_checker.sv
// -----------------------------------------------------------------------------
// sequence_checker
//
// Watches a pair of pipeline registers (in_a = first stage, in_b = second
// stage derived from in_a) and works out whether the second stage follows the
// first with blocking semantics (b == a+1) or non-blocking semantics (b == a).
// It also checks that in_a counts up by one per valid sample. After LOCK_COUNT
// consecutive consistent samples the checker locks onto the detected mode. Any
// later inconsistency drops it into a sticky FAULT state that only clear or
// rst can leave.
//
// Parameters
//   WIDTH       sample width in bits
//   LOCK_COUNT  consecutive consistent samples needed to lock (2..15)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (overrides everything else)
//   in_valid   in_a / in_b carry a sample this cycle
//   in_a       first-stage value (the counter under test)
//   in_b       second-stage value derived from in_a
//   clear      synchronous soft clear back to IDLE (err_count is held)
//   locked     high while in LOCKED
//   mode       00 NONE, 01 BLOCKING, 10 NONBLOCK, 11 MIXED
//   seq_err    one-cycle pulse for each rejected sample
//   err_count  saturating count of rejected samples (optional, see below)
//
// Optional feature
//   Define SEQ_CHK_ERR_COUNT_EN to add the err_count port and its counter.
//   With the macro undefined the port and the counter do not exist.
// -----------------------------------------------------------------------------
module sequence_checker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             clear,
    output logic             locked,
    output logic [1:0]       mode,
    output logic             seq_err
`ifdef SEQ_CHK_ERR_COUNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    // Classes share their encoding with the mode output.
    localparam logic [1:0] CLS_NONE     = 2'b00;
    localparam logic [1:0] CLS_BLOCKING = 2'b01;
    localparam logic [1:0] CLS_NONBLOCK = 2'b10;
    localparam logic [1:0] MODE_MIXED   = 2'b11;

    // The run counter is fixed at 4 bits, which covers the whole legal
    // LOCK_COUNT range.
    localparam int              RUN_W    = 4;
    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1'b1);
    localparam logic [RUN_W-1:0] RUN_ZERO = RUN_W'(1'b0);
    localparam logic [WIDTH-1:0] A_ONE    = WIDTH'(1'b1);
    localparam logic [WIDTH-1:0] A_ZERO   = WIDTH'(1'b0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SYNC   = 2'b01,
        ST_LOCKED = 2'b10,
        ST_FAULT  = 2'b11
    } state_t;

    state_t             state_r;
    logic [RUN_W-1:0]   run_r;
    logic [WIDTH-1:0]   prev_a_r;
    logic [1:0]         cand_r;

    logic [1:0]         cls_s;
    logic               cont_s;
    logic               match_s;
    logic               reject_s;
    logic               err_event_s;
    logic [RUN_W-1:0]   run_inc_s;

    // Work out the relationship between the two pipeline stages. The +1 is
    // done at WIDTH bits so that a == 2^WIDTH-1, b == 0 counts as blocking.
    function automatic logic [1:0] classify(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] a_inc;
        a_inc = a + A_ONE;
        if (b == a_inc) begin
            classify = CLS_BLOCKING;
        end else if (b == a) begin
            classify = CLS_NONBLOCK;
        end else begin
            classify = CLS_NONE;
        end
    endfunction

    // The counter under test must step by exactly one (modulo 2^WIDTH).
    function automatic logic is_continuous(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] prev);
        logic [WIDTH-1:0] prev_inc;
        prev_inc = prev + A_ONE;
        is_continuous = (a == prev_inc);
    endfunction

    assign cls_s     = classify(in_a, in_b);
    assign cont_s    = is_continuous(in_a, prev_a_r);
    assign match_s   = cont_s && (cls_s == cand_r);
    assign run_inc_s = run_r + RUN_ONE;

    // Decide whether the current sample is rejected in the present state.
    // FAULT ignores samples, so nothing is ever rejected there.
    always_comb begin
        reject_s = 1'b0;
        case (state_r)
            ST_IDLE:   reject_s = (cls_s == CLS_NONE);
            ST_SYNC:   reject_s = !match_s;
            ST_LOCKED: reject_s = !match_s;
            ST_FAULT:  reject_s = 1'b0;
            default:   reject_s = 1'b0;
        endcase
    end

    // A sample that arrives together with clear is discarded, so it cannot
    // raise an error.
    assign err_event_s = in_valid && !clear && reject_s;

    // Main checker FSM together with its registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            run_r    <= RUN_ZERO;
            prev_a_r <= A_ZERO;
            cand_r   <= CLS_NONE;
            locked   <= 1'b0;
            mode     <= CLS_NONE;
            seq_err  <= 1'b0;
        end else if (clear) begin
            state_r  <= ST_IDLE;
            run_r    <= RUN_ZERO;
            prev_a_r <= A_ZERO;
            cand_r   <= CLS_NONE;
            locked   <= 1'b0;
            mode     <= CLS_NONE;
            seq_err  <= 1'b0;
        end else begin
            seq_err <= err_event_s;
            if (in_valid) begin
                case (state_r)
                    ST_IDLE: begin
                        if (cls_s != CLS_NONE) begin
                            state_r  <= ST_SYNC;
                            prev_a_r <= in_a;
                            cand_r   <= cls_s;
                            run_r    <= RUN_ONE;
                        end else begin
                            state_r  <= ST_IDLE;
                        end
                    end
                    ST_SYNC: begin
                        if (match_s) begin
                            prev_a_r <= in_a;
                            run_r    <= run_inc_s;
                            if (run_inc_s == LOCK_RUN) begin
                                state_r <= ST_LOCKED;
                                locked  <= 1'b1;
                                mode    <= cand_r;
                            end else begin
                                state_r <= ST_SYNC;
                            end
                        end else if (cls_s != CLS_NONE) begin
                            // A new class (or a broken count) restarts the run
                            // from this sample.
                            state_r  <= ST_SYNC;
                            prev_a_r <= in_a;
                            cand_r   <= cls_s;
                            run_r    <= RUN_ONE;
                        end else begin
                            state_r  <= ST_IDLE;
                            cand_r   <= CLS_NONE;
                            run_r    <= RUN_ZERO;
                        end
                    end
                    ST_LOCKED: begin
                        if (match_s) begin
                            prev_a_r <= in_a;
                        end else begin
                            state_r <= ST_FAULT;
                            locked  <= 1'b0;
                            // A change of class means the stages disagree on
                            // the relationship itself; a pure count skip
                            // keeps the locked mode for diagnosis.
                            if (cls_s != cand_r) begin
                                mode <= MODE_MIXED;
                            end else begin
                                mode <= mode;
                            end
                        end
                    end
                    ST_FAULT: begin
                        state_r <= ST_FAULT;
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        run_r    <= RUN_ZERO;
                        cand_r   <= CLS_NONE;
                        locked   <= 1'b0;
                        mode     <= CLS_NONE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

`ifdef SEQ_CHK_ERR_COUNT_EN
    // Saturating count of rejected samples; clear leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (err_event_s && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end else begin
            err_count <= err_count;
        end
    end
`endif

endmodule

// File: tb/tb_sequence_checker.sv
// -----------------------------------------------------------------------------
// tb_sequence_checker
//
// Self-checking bench for sequence_checker (WIDTH=4, LOCK_COUNT=3). Directed
// scenarios check against hand-derived constants; the random scenario checks
// every cycle against a behavioural model built from the rules: a run length,
// a candidate class, the last accepted count value and a sticky fault flag.
// Define SEQ_CHK_ERR_COUNT_EN to also check err_count.
// -----------------------------------------------------------------------------
module tb_sequence_checker;

    localparam int W   = 4;
    localparam int LC  = 3;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         clear;
    logic         locked;
    logic [1:0]   mode;
    logic         seq_err;
`ifdef SEQ_CHK_ERR_COUNT_EN
    logic [7:0]   err_count;
`endif

    int total;
    int bad;

    // Reference model state.
    bit m_fault;
    int m_run;
    int m_prev;
    int m_cand;
    int exp_mode;
    bit exp_err;
    bit exp_locked;
    int exp_cnt;

    sequence_checker #(.WIDTH(W), .LOCK_COUNT(LC)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_a     (in_a),
        .in_b     (in_b),
        .clear    (clear),
        .locked   (locked),
        .mode     (mode),
        .seq_err  (seq_err)
`ifdef SEQ_CHK_ERR_COUNT_EN
        ,
        .err_count(err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cls_of(input int a, input int b);
        if (b == (a + 1) % MOD) return 1;
        else if (b == a) return 2;
        else return 0;
    endfunction

    task automatic model_update(input bit v, input int a, input int b,
                                input bit clr, input bit r);
        int  c;
        bit  good;
        exp_err = 1'b0;
        if (r) begin
            m_fault = 1'b0; m_run = 0; m_prev = 0; m_cand = 0;
            exp_mode = 0; exp_cnt = 0;
        end else if (clr) begin
            m_fault = 1'b0; m_run = 0; m_cand = 0; exp_mode = 0;
        end else if (v && !m_fault) begin
            c    = cls_of(a, b);
            good = (m_run > 0) && (c == m_cand) && (a == (m_prev + 1) % MOD);
            if (m_run == 0) begin
                if (c != 0) begin m_run = 1; m_cand = c; m_prev = a; end
                else exp_err = 1'b1;
            end else if (good) begin
                m_prev = a;
                if (m_run < LC) begin
                    m_run++;
                    if (m_run == LC) exp_mode = m_cand;
                end
            end else begin
                exp_err = 1'b1;
                if (m_run >= LC) begin
                    m_fault = 1'b1;
                    if (c != m_cand) exp_mode = 3;
                end else if (c != 0) begin
                    m_run = 1; m_cand = c; m_prev = a;
                end else begin
                    m_run = 0; m_cand = 0;
                end
            end
            if (exp_err && exp_cnt < 255) exp_cnt++;
        end
        exp_locked = !m_fault && (m_run >= LC);
    endtask

    // Drive one cycle of inputs, clock it, then advance the model.
    task automatic step(input bit v, input int a, input int b,
                        input bit clr, input bit r);
        in_valid = v; in_a = W'(a % MOD); in_b = W'(b % MOD);
        clear = clr; rst = r;
        @(posedge clk);
        #1;
        model_update(v, a % MOD, b % MOD, clr, r);
        in_valid = 1'b0; clear = 1'b0; rst = 1'b0;
    endtask

    task automatic do_reset();
        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        step(1'b1, 1, 2, 1'b1, 1'b1);  // rst overrides clear and in_valid
        do_reset();
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %0b want 0", locked); end
        total++; if (mode !== 2'b00) begin bad++; $display("FAIL rst_mode: got %0b want 00", mode); end
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL rst_seq_err: got %0b want 0", seq_err); end
`ifdef SEQ_CHK_ERR_COUNT_EN
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
`endif
    endtask

    task automatic test_blocking_lock();
        int seq_a [3] = '{1, 2, 3};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, seq_a[i], seq_a[i] + 1, 1'b0, 1'b0);
            total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL blk_seq_err[%0d]: got %0b want 0", i, seq_err); end
            if (i < 2) begin
                total++; if (locked !== 1'b0) begin bad++; $display("FAIL blk_early_lock[%0d]: got %0b want 0", i, locked); end
            end
        end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL blk_locked: got %0b want 1", locked); end
        total++; if (mode !== 2'b01) begin bad++; $display("FAIL blk_mode: got %0b want 01", mode); end
    endtask

    task automatic test_nonblock_lock();
        do_reset();
        for (int i = 1; i <= 3; i++) step(1'b1, i, i, 1'b0, 1'b0);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL nb_locked: got %0b want 1", locked); end
        total++; if (mode !== 2'b10) begin bad++; $display("FAIL nb_mode: got %0b want 10", mode); end
    endtask

    task automatic test_wrap_lock();
        int seq_a [3] = '{14, 15, 0};
        int seq_b [3] = '{15, 0, 1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, seq_a[i], seq_b[i], 1'b0, 1'b0);
            total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL wrap_seq_err[%0d]: got %0b want 0", i, seq_err); end
        end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL wrap_locked: got %0b want 1", locked); end
        total++; if (mode !== 2'b01) begin bad++; $display("FAIL wrap_mode: got %0b want 01", mode); end
    endtask

    task automatic test_gaps();
        do_reset();
        step(1'b1, 1, 2, 1'b0, 1'b0);
        step(1'b0, 9, 3, 1'b0, 1'b0);
        step(1'b1, 2, 3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 7, 1, 1'b0, 1'b0);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL gap_early_lock: got %0b want 0", locked); end
        step(1'b1, 3, 4, 1'b0, 1'b0);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL gap_locked: got %0b want 1", locked); end
    endtask

    task automatic test_fault();
        test_blocking_lock();
        step(1'b1, 5, 5, 1'b0, 1'b0);
        total++; if (seq_err !== 1'b1) begin bad++; $display("FAIL flt_seq_err: got %0b want 1", seq_err); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL flt_locked: got %0b want 0", locked); end
        total++; if (mode !== 2'b11) begin bad++; $display("FAIL flt_mode: got %0b want 11", mode); end
`ifdef SEQ_CHK_ERR_COUNT_EN
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL flt_err_count: got %0d want 1", err_count); end
`endif
        step(1'b1, 4, 5, 1'b0, 1'b0);
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL flt_pulse_len: got %0b want 0", seq_err); end
        step(1'b1, 9, 2, 1'b0, 1'b0);  // garbage is ignored while faulted
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL flt_ignored: got %0b want 0", seq_err); end
        total++; if (mode !== 2'b11 || locked !== 1'b0) begin bad++; $display("FAIL flt_sticky: got mode=%0b locked=%0b want 11/0", mode, locked); end
`ifdef SEQ_CHK_ERR_COUNT_EN
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL flt_count_held: got %0d want 1", err_count); end
`endif
        // Same class but a count skip keeps the locked mode.
        test_blocking_lock();
        step(1'b1, 9, 10, 1'b0, 1'b0);
        total++; if (seq_err !== 1'b1) begin bad++; $display("FAIL skip_seq_err: got %0b want 1", seq_err); end
        total++; if (mode !== 2'b01 || locked !== 1'b0) begin bad++; $display("FAIL skip_mode: got mode=%0b locked=%0b want 01/0", mode, locked); end
    endtask

    task automatic test_clear_in_sync();
        do_reset();
        step(1'b1, 1, 2, 1'b0, 1'b0);
        step(1'b1, 2, 3, 1'b0, 1'b0);
        step(1'b1, 3, 4, 1'b1, 1'b0);
        total++; if (locked !== 1'b0 || mode !== 2'b00 || seq_err !== 1'b0) begin bad++; $display("FAIL clr_outputs: got locked=%0b mode=%0b err=%0b want 0/00/0", locked, mode, seq_err); end
        step(1'b1, 7, 8, 1'b0, 1'b0);
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL clr_first: got %0b want 0", seq_err); end
        step(1'b1, 8, 9, 1'b0, 1'b0);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL clr_run2: got %0b want 0", locked); end
        step(1'b1, 9, 10, 1'b0, 1'b0);
        total++; if (locked !== 1'b1 || mode !== 2'b01) begin bad++; $display("FAIL clr_relock: got locked=%0b mode=%0b want 1/01", locked, mode); end
    endtask

    task automatic test_sync_restart();
        do_reset();
        step(1'b1, 1, 2, 1'b0, 1'b0);
        step(1'b1, 2, 3, 1'b0, 1'b0);
        step(1'b1, 3, 3, 1'b0, 1'b0);
        total++; if (seq_err !== 1'b1 || locked !== 1'b0) begin bad++; $display("FAIL rs_err: got err=%0b locked=%0b want 1/0", seq_err, locked); end
        step(1'b1, 4, 4, 1'b0, 1'b0);
        step(1'b1, 5, 5, 1'b0, 1'b0);
        total++; if (locked !== 1'b1 || mode !== 2'b10) begin bad++; $display("FAIL rs_lock: got locked=%0b mode=%0b want 1/10", locked, mode); end
        do_reset();
        step(1'b1, 1, 7, 1'b0, 1'b0);
        total++; if (seq_err !== 1'b1 || mode !== 2'b00) begin bad++; $display("FAIL idle_unclass: got err=%0b mode=%0b want 1/00", seq_err, mode); end
    endtask

    task automatic test_rst_in_locked();
        test_nonblock_lock();
        step(1'b1, 4, 4, 1'b0, 1'b1);
        total++; if (locked !== 1'b0 || mode !== 2'b00 || seq_err !== 1'b0) begin bad++; $display("FAIL rl_outputs: got locked=%0b mode=%0b err=%0b want 0/00/0", locked, mode, seq_err); end
        step(1'b1, 9, 9, 1'b0, 1'b0);
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL rl_first: got %0b want 0", seq_err); end
        step(1'b1, 10, 10, 1'b0, 1'b0);
        step(1'b1, 11, 11, 1'b0, 1'b0);
        total++; if (locked !== 1'b1 || mode !== 2'b10) begin bad++; $display("FAIL rl_relock: got locked=%0b mode=%0b want 1/10", locked, mode); end
    endtask

`ifdef SEQ_CHK_ERR_COUNT_EN
    task automatic test_err_saturate();
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, 1, 7, 1'b0, 1'b0);
        total++; if (err_count !== 8'd255) begin bad++; $display("FAIL sat_count: got %0d want 255", err_count); end
        step(1'b1, 0, 0, 1'b1, 1'b0);
        total++; if (err_count !== 8'd255) begin bad++; $display("FAIL sat_clear_held: got %0d want 255", err_count); end
    endtask
`endif

    task automatic test_random();
        int  ga;
        int  gc;
        int  ra;
        int  rb;
        bit  v;
        bit  c;
        bit  r;
        ga = 0; gc = 1;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 249) == 0);
            c = ($urandom_range(0, 79) == 0);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) gc = 3 - gc;
            if ($urandom_range(0, 9) < 8) ra = (ga + 1) % MOD;
            else ra = $urandom_range(0, MOD - 1);
            if ($urandom_range(0, 19) == 0) rb = $urandom_range(0, MOD - 1);
            else rb = (gc == 1) ? (ra + 1) % MOD : ra;
            if (v) ga = ra;
            step(v, ra, rb, c, r);
            total++; if (locked !== exp_locked) begin bad++; $display("FAIL rnd_locked@%0d: got %0b want %0b", n, locked, exp_locked); end
            total++; if (mode !== 2'(exp_mode)) begin bad++; $display("FAIL rnd_mode@%0d: got %0b want %0b", n, mode, 2'(exp_mode)); end
            total++; if (seq_err !== exp_err) begin bad++; $display("FAIL rnd_seq_err@%0d: got %0b want %0b", n, seq_err, exp_err); end
`ifdef SEQ_CHK_ERR_COUNT_EN
            total++; if (err_count !== 8'(exp_cnt)) begin bad++; $display("FAIL rnd_err_count@%0d: got %0d want %0d", n, err_count, exp_cnt); end
`endif
        end
    endtask

    initial begin
        total = 0; bad = 0;
        m_fault = 1'b0; m_run = 0; m_prev = 0; m_cand = 0;
        exp_mode = 0; exp_err = 1'b0; exp_locked = 1'b0; exp_cnt = 0;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        test_reset();
        test_blocking_lock();
        test_nonblock_lock();
        test_wrap_lock();
        test_gaps();
        test_fault();
        test_clear_in_sync();
        test_sync_restart();
        test_rst_in_locked();
`ifdef SEQ_CHK_ERR_COUNT_EN
        test_err_saturate();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
